udma_cfg_demux_n: RTL and testbench

//  Parametrised N-way demux for the uDMA peripheral config bus, successor to the 2-way bit-5 split in the hyper top.
//  One upstream request at a time is registered, decoded on an address field and routed to one of NB_TGT register files.

---
 rtl/udma_cfg_demux_n.sv | 131 +++++++++++++
 tb/tb_udma_cfg_demux_n.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/udma_cfg_demux_n.sv
// N-way demux for the uDMA peripheral cfg bus: one registered request at a
// time, routed by an address field, with decode-miss and timeout rejection.
module udma_cfg_demux_n #(
    parameter int NB_TGT  = 4,
    parameter int ADDR_W  = 6,
    parameter int SEL_LSB = 5,
    parameter int SEL_W   = $clog2(NB_TGT),
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 15,
    parameter logic [DATA_W-1:0] ERR_DATA = DATA_W'(32'hDEAD_BEEF)
) (
    input  logic                     sys_clk_i,
    input  logic                     rst_i,
    input  logic                     cfg_valid_i,
    input  logic [ADDR_W-1:0]        cfg_addr_i,
    input  logic                     cfg_rwn_i,
    input  logic [DATA_W-1:0]        cfg_data_i,
    output logic                     cfg_ready_o,
    output logic [DATA_W-1:0]        cfg_data_o,
    output logic                     cfg_err_o,
    output logic [NB_TGT-1:0]        tgt_valid_o,
    output logic [ADDR_W-1:0]        tgt_addr_o,
    output logic                     tgt_rwn_o,
    output logic [DATA_W-1:0]        tgt_data_o,
    input  logic [NB_TGT-1:0]        tgt_ready_i,
    input  logic [NB_TGT*DATA_W-1:0] tgt_data_i,
    output logic                     busy_o,
    output logic [7:0]               err_cnt_o
);

    localparam int NSEL  = 1 << SEL_W;
    localparam int PAD_W = (SEL_LSB + SEL_W > ADDR_W) ? SEL_LSB + SEL_W : ADDR_W;
    localparam int CNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        RESP
    } state_t;

    state_t           state;
    logic [SEL_W-1:0] sel;
    logic [SEL_W-1:0] sel_q;
    logic             hit;
    logic [CNT_W-1:0] cnt;
    logic             expired;
    logic [NSEL-1:0]  rdy_ext;
    logic [DATA_W-1:0] rd_arr [NSEL];

    // Field may extend past the address MSB; missing bits read as zero.
    assign sel = SEL_W'(PAD_W'(cfg_addr_i) >> SEL_LSB);
    assign hit = ({1'b0, sel} < (SEL_W + 1)'(NB_TGT));

    assign rdy_ext = NSEL'(tgt_ready_i);

    for (genvar k = 0; k < NSEL; k++) begin : g_rd
        if (k < NB_TGT) begin : g_on
            assign rd_arr[k] = tgt_data_i[k*DATA_W +: DATA_W];
        end else begin : g_off
            assign rd_arr[k] = '0;
        end
    end

    assign expired = (TIMEOUT != 0) && (cnt == CNT_W'(TIMEOUT - 1));
    assign busy_o  = (state != IDLE);

    always_ff @(posedge sys_clk_i or posedge rst_i) begin
        if (rst_i) begin
            state       <= IDLE;
            sel_q       <= '0;
            cnt         <= '0;
            cfg_ready_o <= 1'b0;
            cfg_data_o  <= '0;
            cfg_err_o   <= 1'b0;
            tgt_valid_o <= '0;
            tgt_addr_o  <= '0;
            tgt_rwn_o   <= 1'b0;
            tgt_data_o  <= '0;
            err_cnt_o   <= '0;
        end else begin
            cfg_ready_o <= 1'b0;
            cfg_data_o  <= '0;
            cfg_err_o   <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (cfg_valid_i) begin
                        if (hit) begin
                            sel_q       <= sel;
                            tgt_addr_o  <= cfg_addr_i;
                            tgt_rwn_o   <= cfg_rwn_i;
                            tgt_data_o  <= cfg_data_i;
                            tgt_valid_o <= NB_TGT'(1) << sel;
                            cnt         <= '0;
                            state       <= REQ;
                        end else begin
                            cfg_ready_o <= 1'b1;
                            cfg_data_o  <= ERR_DATA;
                            cfg_err_o   <= 1'b1;
                            state       <= RESP;
                        end
                    end
                end
                REQ: begin
                    // Ready wins over an expiry in the same cycle.
                    if (rdy_ext[sel_q]) begin
                        tgt_valid_o <= '0;
                        cfg_ready_o <= 1'b1;
                        cfg_data_o  <= tgt_rwn_o ? rd_arr[sel_q] : '0;
                        state       <= RESP;
                    end else if (expired) begin
                        tgt_valid_o <= '0;
                        cfg_ready_o <= 1'b1;
                        cfg_data_o  <= tgt_rwn_o ? ERR_DATA : '0;
                        cfg_err_o   <= 1'b1;
                        state       <= RESP;
                    end else if (TIMEOUT != 0) begin
                        cnt <= cnt + 1'b1;
                    end
                end
                RESP: begin
                    if (cfg_err_o && err_cnt_o != 8'hFF) begin
                        err_cnt_o <= err_cnt_o + 8'd1;
                    end
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_udma_cfg_demux_n.sv
// Bench for udma_cfg_demux_n: a 4-way instance for routing/timeout/rate
// and a 3-way instance for decode misses and error-count saturation.
module tb_udma_cfg_demux_n;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // 4-way instance
    logic         cfg_valid = 1'b0;
    logic [6:0]   cfg_addr = '0;
    logic         cfg_rwn = 1'b0;
    logic [31:0]  cfg_wdata = '0;
    logic         cfg_ready;
    logic [31:0]  cfg_rdata;
    logic         cfg_err;
    logic [3:0]   tgt_valid;
    logic [6:0]   tgt_addr;
    logic         tgt_rwn;
    logic [31:0]  tgt_wdata;
    logic [3:0]   tgt_ready = '0;
    logic [127:0] tgt_rdata = '0;
    logic         busy;
    logic [7:0]   err_cnt;

    udma_cfg_demux_n #(
        .NB_TGT(4), .ADDR_W(7), .SEL_LSB(5), .DATA_W(32), .TIMEOUT(15)
    ) dut4 (
        .sys_clk_i(clk), .rst_i(rst),
        .cfg_valid_i(cfg_valid), .cfg_addr_i(cfg_addr),
        .cfg_rwn_i(cfg_rwn), .cfg_data_i(cfg_wdata),
        .cfg_ready_o(cfg_ready), .cfg_data_o(cfg_rdata), .cfg_err_o(cfg_err),
        .tgt_valid_o(tgt_valid), .tgt_addr_o(tgt_addr),
        .tgt_rwn_o(tgt_rwn), .tgt_data_o(tgt_wdata),
        .tgt_ready_i(tgt_ready), .tgt_data_i(tgt_rdata),
        .busy_o(busy), .err_cnt_o(err_cnt)
    );

    // 3-way instance
    logic        v3 = 1'b0;
    logic [6:0]  a3 = '0;
    logic        r3_ready;
    logic [31:0] r3_data;
    logic        r3_err;
    logic [2:0]  t3_valid;
    logic [6:0]  t3_addr;
    logic        t3_rwn;
    logic [31:0] t3_wdata;
    logic        busy3;
    logic [7:0]  err_cnt3;

    udma_cfg_demux_n #(
        .NB_TGT(3), .ADDR_W(7), .SEL_LSB(5), .DATA_W(32), .TIMEOUT(15)
    ) dut3 (
        .sys_clk_i(clk), .rst_i(rst),
        .cfg_valid_i(v3), .cfg_addr_i(a3),
        .cfg_rwn_i(1'b1), .cfg_data_i(32'h0),
        .cfg_ready_o(r3_ready), .cfg_data_o(r3_data), .cfg_err_o(r3_err),
        .tgt_valid_o(t3_valid), .tgt_addr_o(t3_addr),
        .tgt_rwn_o(t3_rwn), .tgt_data_o(t3_wdata),
        .tgt_ready_i(3'b000), .tgt_data_i(96'h0),
        .busy_o(busy3), .err_cnt_o(err_cnt3)
    );

    int checks = 0;
    int errors = 0;
    int m_errcnt = 0;

    task automatic chk(input string tag, input logic [127:0] obs,
                       input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One access on the 4-way instance. Targets answer `lat` REQ cycles
    // after the request appears; unselected targets raise random ready.
    task automatic access(input logic [6:0] a, input logic rw,
                          input logic [31:0] wd, input int lat,
                          input bit b2b, input bit full_nz,
                          output int t_resp);
        logic [1:0]  s;
        logic [3:0]  oh;
        logic [3:0]  nz;
        logic [31:0] td [4];
        logic [31:0] exp_d;
        logic        exp_e;
        int          exp_i;
        int          got_i;
        int          n_tv;
        s  = a[6:5];
        oh = 4'b0001 << s;
        for (int k = 0; k < 4; k++) td[k] = $urandom;
        tgt_rdata = {td[3], td[2], td[1], td[0]};
        exp_e = (lat > 14);
        exp_i = 2 + (exp_e ? 14 : lat);
        exp_d = rw ? (exp_e ? 32'hDEAD_BEEF : td[s]) : 32'h0;
        cfg_valid = 1'b1;
        cfg_addr  = a;
        cfg_rwn   = rw;
        cfg_wdata = wd;
        tgt_ready = '0;
        if (b2b) begin
            @(negedge clk);
            chk("b2b_idle", {busy, cfg_ready, tgt_valid}, 6'h0);
        end
        got_i  = -1;
        n_tv   = 0;
        t_resp = -1;
        for (int i = 1; i <= 40 && got_i < 0; i++) begin
            @(negedge clk);
            if (i == 1) begin
                chk("err_cnt", err_cnt, m_errcnt);
                chk("tgt_bus", {tgt_addr, tgt_rwn, tgt_wdata}, {a, rw, wd});
            end
            if (cfg_ready) begin
                got_i  = i;
                t_resp = cyc;
                chk("rdata", cfg_rdata, exp_d);
                chk("err", cfg_err, exp_e);
                chk("resp_tv", tgt_valid, 4'h0);
            end else begin
                if (tgt_valid == oh) n_tv++;
                nz = full_nz ? 4'hF : 4'($urandom);
                tgt_ready = ((i - 1 >= lat) ? oh : 4'h0) | (nz & ~oh);
            end
        end
        chk("resp_cycle", got_i, exp_i);
        chk("tv_cycles", n_tv, exp_i - 1);
        cfg_valid = 1'b0;
        tgt_ready = '0;
        if (exp_e && m_errcnt < 255) m_errcnt++;
    endtask

    initial begin
        int t0;
        int t1;
        int m3;
        bit bb;
        repeat (3) @(negedge clk);
        chk("reset_outs",
            {cfg_ready, cfg_rdata, cfg_err, tgt_valid, tgt_addr,
             tgt_rwn, tgt_wdata, busy, err_cnt}, '0);
        rst = 1'b0;
        @(negedge clk);

        // directed: read tgt1, write tgt0, ignored foreign ready
        access(7'h25, 1'b1, 32'h0, 0, 1'b0, 1'b0, t0);
        @(negedge clk);
        access(7'h05, 1'b0, 32'h1234, 0, 1'b0, 1'b0, t0);
        @(negedge clk);
        access(7'h25, 1'b1, 32'h0, 3, 1'b0, 1'b1, t0);
        @(negedge clk);

        // timeouts and ready on the final REQ cycle
        access(7'h45, 1'b1, 32'h0, 20, 1'b0, 1'b0, t0);
        @(negedge clk);
        access(7'h45, 1'b1, 32'h0, 14, 1'b0, 1'b0, t0);
        @(negedge clk);
        access(7'h65, 1'b0, 32'h77, 15, 1'b0, 1'b0, t0);
        @(negedge clk);

        // four back-to-back reads, one response per 3 cycles
        access(7'h25, 1'b1, 32'h0, 0, 1'b0, 1'b0, t0);
        for (int n = 0; n < 3; n++) begin
            access(7'h65 - 7'(n * 32), 1'b1, 32'h0, 0, 1'b1, 1'b0, t1);
            chk("b2b_rate", t1 - t0, 3);
            t0 = t1;
        end
        @(negedge clk);

        // randomized traffic
        for (int n = 0; n < 30; n++) begin
            bb = 1'($urandom_range(0, 1));
            if (!bb) repeat ($urandom_range(1, 3)) @(negedge clk);
            access(7'($urandom), 1'($urandom), $urandom,
                   $urandom_range(0, 16), bb, 1'b0, t0);
        end
        @(negedge clk);

        // reset during REQ
        cfg_valid = 1'b1;
        cfg_addr  = 7'h45;
        cfg_rwn   = 1'b1;
        tgt_ready = '0;
        @(negedge clk);
        @(negedge clk);
        chk("pre_rst_req", {busy, tgt_valid}, 5'b1_0100);
        #2 rst = 1'b1;
        #1;
        chk("rst_async", {busy, tgt_valid, cfg_ready}, 6'h0);
        cfg_valid = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        m_errcnt = 0;
        @(negedge clk);
        chk("post_rst", {err_cnt, cfg_ready}, 9'h0);
        access(7'h25, 1'b1, 32'h0, 1, 1'b0, 1'b0, t0);
        @(negedge clk);

        // 3-way decode miss and error-count saturation
        m3 = 0;
        for (int n = 0; n < 260; n++) begin
            v3 = 1'b1;
            a3 = 7'h65;
            @(negedge clk);
            if (n == 0) begin
                chk("miss_resp", {r3_ready, r3_data, r3_err, t3_valid},
                    {1'b1, 32'hDEAD_BEEF, 1'b1, 3'b000});
                chk("miss_busy", busy3, 1'b1);
            end
            v3 = 1'b0;
            @(negedge clk);
            if (m3 < 255) m3++;
            if (n == 0) chk("miss_cnt", err_cnt3, m3);
        end
        chk("cnt_sat", err_cnt3, m3);
        chk("miss_idle", {r3_ready, busy3, t3_valid}, 5'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
